// File: rtl/l1_ahb_mtx_arb_m0.sv
// MI0 output-stage arbiter: grants the address phase to one input stage and tracks
// the data-phase owner. Grants hold through SEQ/BUSY beats and locked sequences.
module l1_ahb_mtx_arb_m0 #(
  parameter int NUM_IN = 3,
  parameter bit ARB_RR = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_IN-1:0]     req_in,
  input  logic [2*NUM_IN-1:0]   trans_in,
  input  logic [NUM_IN-1:0]     lock_in,
  input  logic                  HREADYM,
  output logic [NUM_IN-1:0]     grant_out,
  output logic                  no_port,
  output logic [NUM_IN-1:0]     data_owner,
  output logic [NUM_IN-1:0]     active_out
);
  localparam int IW = $clog2(NUM_IN);

  logic [NUM_IN-1:0] grant_q, grant_d;
  logic              no_port_q, no_port_d;
  logic [NUM_IN-1:0] data_owner_q, data_owner_d;
  logic [IW-1:0]     last_idx_q, last_idx_d;
  logic              locked_q, locked_d;

  logic [NUM_IN-1:0] valid, cont;
  logic              hold, owner_lock, hi_found;
  logic [IW-1:0]     hi_win, lo_win, win;

  // valid = NONSEQ/SEQ; cont = owner wants to keep the bus (SEQ/BUSY or lock)
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign valid[i] = req_in[i] & trans_in[2*i+1];
    assign cont[i]  = (req_in[i] & ((trans_in[2*i+1 -: 2] == 2'b11) |
                                    (trans_in[2*i+1 -: 2] == 2'b01))) | lock_in[i];
  end

  assign hold       = ~no_port_q & |(grant_q & cont);
  assign owner_lock = |(grant_q & lock_in);

  // Round-robin: lowest valid index above last_idx, else wrap to lowest valid overall
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!hi_found && valid[i] && (IW'(i) > last_idx_q)) begin
        hi_found = 1'b1;
        hi_win   = IW'(i);
      end
    end
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (valid[i]) lo_win = IW'(i);
    end
    win = (ARB_RR && hi_found) ? hi_win : lo_win;
  end

  always_comb begin
    grant_d      = grant_q;
    no_port_d    = no_port_q;
    data_owner_d = data_owner_q;
    last_idx_d   = last_idx_q;
    locked_d     = locked_q;
    if (HREADYM) begin
      // The transfer whose address phase just completed moves into its data phase
      data_owner_d = no_port_q ? '0 : grant_q;
      if (hold || locked_q) begin
        grant_d = grant_q;
      end else if (|valid) begin
        grant_d    = NUM_IN'(1) << win;
        no_port_d  = 1'b0;
        last_idx_d = win;
      end else begin
        no_port_d = 1'b1;
      end
      if (!no_port_q && owner_lock) locked_d = 1'b1;
      else if (!owner_lock)         locked_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q      <= NUM_IN'(1);
      no_port_q    <= 1'b1;
      data_owner_q <= '0;
      last_idx_q   <= IW'(NUM_IN-1);
      locked_q     <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      no_port_q    <= no_port_d;
      data_owner_q <= data_owner_d;
      last_idx_q   <= last_idx_d;
      locked_q     <= locked_d;
    end
  end

  assign grant_out  = grant_q;
  assign no_port    = no_port_q;
  assign data_owner = data_owner_q;
  assign active_out = grant_q & {NUM_IN{~no_port_q}};
endmodule

// File: tb/tb_l1_ahb_mtx_arb_m0.sv
// Directed bench for the MI0 arbiter: round-robin instance fully checked,
// fixed-priority instance checked on reset and contention.
module tb_l1_ahb_mtx_arb_m0;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [2:0] req, lock;
  logic [5:0] trans;
  logic       hready;
  logic [2:0] rr_grant, rr_data, rr_act, fx_grant, fx_data, fx_act;
  logic       rr_np, fx_np;
  int         n_err = 0;
  int         n_chk = 0;

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_arb_m0 #(.NUM_IN(3), .ARB_RR(1'b1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .req_in(req), .trans_in(trans), .lock_in(lock),
    .HREADYM(hready), .grant_out(rr_grant), .no_port(rr_np), .data_owner(rr_data),
    .active_out(rr_act));

  l1_ahb_mtx_arb_m0 #(.NUM_IN(3), .ARB_RR(1'b0)) u_fx (
    .HCLK(HCLK), .HRESET(HRESET), .req_in(req), .trans_in(trans), .lock_in(lock),
    .HREADYM(hready), .grant_out(fx_grant), .no_port(fx_np), .data_owner(fx_data),
    .active_out(fx_act));

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic tr(input int i, input logic [1:0] t);
    trans[2*i +: 2] = t;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected active_out is derived from the expected grant/no_port
  task automatic chk_rr(input string tag, input logic [2:0] g, input logic np,
                        input logic [2:0] d);
    chk({tag, "_grant"}, 8'(rr_grant), 8'(g));
    chk({tag, "_noport"}, 8'(rr_np), 8'(np));
    chk({tag, "_data"}, 8'(rr_data), 8'(d));
    chk({tag, "_active"}, 8'(rr_act), np ? 8'h0 : 8'(g));
  endtask

  initial begin
    HRESET = 1'b1;
    req = 3'($urandom); trans = 6'($urandom); lock = 3'($urandom); hready = 1'($urandom);
    step();
    chk_rr("rst", 3'b001, 1'b1, 3'b000);
    chk("rst_fx_grant", 8'(fx_grant), 8'h1);
    chk("rst_fx_active", 8'(fx_act), 8'h0);

    HRESET = 1'b0; req = '0; trans = '0; lock = '0; hready = 1'b1;
    step();
    chk_rr("park", 3'b001, 1'b1, 3'b000);

    // Single NONSEQ from input 2
    req[2] = 1'b1; tr(2, NS);
    step(); chk_rr("single_n", 3'b100, 1'b0, 3'b000);
    req = '0; trans = '0;
    step(); chk_rr("single_n1", 3'b100, 1'b1, 3'b100);
    step(); chk_rr("single_n2", 3'b100, 1'b1, 3'b000);

    // Continuous contention from all inputs
    req = 3'b111; tr(0, NS); tr(1, NS); tr(2, NS);
    step(); chk_rr("rr0", 3'b001, 1'b0, 3'b000); chk("fx0", 8'(fx_grant), 8'h1);
    step(); chk_rr("rr1", 3'b010, 1'b0, 3'b001); chk("fx1", 8'(fx_grant), 8'h1);
    chk("fx1_data", 8'(fx_data), 8'h1);
    step(); chk_rr("rr2", 3'b100, 1'b0, 3'b010); chk("fx2", 8'(fx_grant), 8'h1);
    step(); chk_rr("rr3", 3'b001, 1'b0, 3'b100); chk("fx3", 8'(fx_grant), 8'h1);
    req = '0; trans = '0;
    step(); chk_rr("rr_idle", 3'b001, 1'b1, 3'b001);

    // Burst on input 0 with input 1 waiting
    req[0] = 1'b1; tr(0, NS);
    step(); chk_rr("b0", 3'b001, 1'b0, 3'b000);
    tr(0, SEQ); req[1] = 1'b1; tr(1, NS);
    step(); chk_rr("b1", 3'b001, 1'b0, 3'b001);
    tr(0, BUSY);
    step(); chk_rr("b2_busy", 3'b001, 1'b0, 3'b001);
    tr(0, SEQ);
    step(); chk_rr("b3", 3'b001, 1'b0, 3'b001);
    step(); chk_rr("b4", 3'b001, 1'b0, 3'b001);
    tr(0, IDLE); req[0] = 1'b0;
    step(); chk_rr("b5_rel", 3'b010, 1'b0, 3'b001);

    // Wait states freeze everything
    req = '0; trans = '0;
    step(); chk_rr("w_park", 3'b010, 1'b1, 3'b010);
    hready = 1'b0; req[2] = 1'b1; tr(2, NS);
    step(); chk_rr("w1", 3'b010, 1'b1, 3'b010);
    step(); chk_rr("w2", 3'b010, 1'b1, 3'b010);
    step(); chk_rr("w3", 3'b010, 1'b1, 3'b010);
    hready = 1'b1;
    step(); chk_rr("w_go", 3'b100, 1'b0, 3'b000);

    // Locked sequence from input 1 while input 0 requests
    req = '0; trans = '0;
    step(); chk_rr("l_park", 3'b100, 1'b1, 3'b100);
    req[1] = 1'b1; tr(1, NS); lock[1] = 1'b1;
    step(); chk_rr("l0", 3'b010, 1'b0, 3'b000);
    req[0] = 1'b1; tr(0, NS); tr(1, IDLE);
    step(); chk_rr("l1", 3'b010, 1'b0, 3'b010);
    step(); chk_rr("l2", 3'b010, 1'b0, 3'b010);
    lock[1] = 1'b0;
    step(); chk_rr("l3_unlock", 3'b010, 1'b0, 3'b010);
    step(); chk_rr("l4", 3'b001, 1'b0, 3'b010);

    // Reset in the middle of a burst
    tr(0, SEQ);
    step(); chk_rr("mb", 3'b001, 1'b0, 3'b001);
    HRESET = 1'b1;
    step(); chk_rr("mb_rst", 3'b001, 1'b1, 3'b000);
    chk("mb_rst_fx_data", 8'(fx_data), 8'h0);
    HRESET = 1'b0; req = 3'b111; tr(0, NS); tr(1, NS); tr(2, NS);
    step(); chk_rr("post_rst", 3'b001, 1'b0, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
